// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_pkg
// Description : Shared constants, state encoding and decode helpers for the
//               multi-cycle MIPS-subset core.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_pkg;

    localparam int c_XLEN = 32;

    // Primary opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] c_FN_SLL = 6'h00;
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    // ALU control codes
    localparam logic [3:0] c_ALU_ADD = 4'd0;
    localparam logic [3:0] c_ALU_SUB = 4'd1;
    localparam logic [3:0] c_ALU_AND = 4'd2;
    localparam logic [3:0] c_ALU_OR  = 4'd3;
    localparam logic [3:0] c_ALU_SLT = 4'd4;
    localparam logic [3:0] c_ALU_SLL = 4'd5;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    function automatic logic [c_XLEN-1:0] signExt(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [3:0] functToAlu(input logic [5:0] funct);
        case (funct)
            c_FN_SUB: return c_ALU_SUB;
            c_FN_AND: return c_ALU_AND;
            c_FN_OR:  return c_ALU_OR;
            c_FN_SLT: return c_ALU_SLT;
            c_FN_SLL: return c_ALU_SLL;
            default:  return c_ALU_ADD;
        endcase
    endfunction

    // An R-type with an unknown funct is as unsupported as an unknown opcode
    function automatic logic isLegal(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            c_OP_RTYPE: begin
                case (funct)
                    c_FN_SLL, c_FN_ADD, c_FN_SUB,
                    c_FN_AND, c_FN_OR, c_FN_SLT: return 1'b1;
                    default:                    return 1'b0;
                endcase
            end
            c_OP_J, c_OP_BEQ, c_OP_BNE,
            c_OP_ADDI, c_OP_LW, c_OP_SW: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mc_regfile.sv
`default_nettype none
// ============================================================================
// Module      : mc_regfile
// Description : 32 x 32 register file, two asynchronous read ports, one
//               synchronous write port, register 0 hardwired to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_regfile
    import mc_pkg::*;
(
    input  logic              clk,
    input  logic [4:0]        i_rdAddrA,
    output logic [c_XLEN-1:0] o_rdDataA,
    input  logic [4:0]        i_rdAddrB,
    output logic [c_XLEN-1:0] o_rdDataB,
    input  logic              i_we,
    input  logic [4:0]        i_wrAddr,
    input  logic [c_XLEN-1:0] i_wrData
);

    logic [c_XLEN-1:0] r_regs [0:31];

    // Writes to register 0 are dropped so it always reads back as zero
    always_ff @(posedge clk) begin
        if (i_we && (i_wrAddr != 5'd0)) begin
            r_regs[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdDataA = (i_rdAddrA == 5'd0) ? '0 : r_regs[i_rdAddrA];
    assign o_rdDataB = (i_rdAddrB == 5'd0) ? '0 : r_regs[i_rdAddrB];

endmodule
`default_nettype wire

// File: rtl/mc_core.sv
`default_nettype none
// ============================================================================
// Module      : mc_core
// Description : Multi-cycle MIPS-subset core sharing one instruction/data
//               memory port with a req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_core
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [c_XLEN-1:0] mem_addr,
    output logic [c_XLEN-1:0] mem_wdata,
    input  logic [c_XLEN-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              retire,
    output logic              halted,
    output logic [c_XLEN-1:0] dbg_pc
);

    state_e            r_state;
    logic [c_XLEN-1:0] r_pc, r_ir, r_a, r_b, r_aluOut, r_mdr;
    logic              r_memReq, r_memWe, r_halted;
    logic [c_XLEN-1:0] r_memAddr, r_memWdata;

    logic [5:0]        w_op, w_funct;
    logic [4:0]        w_rs, w_rt, w_rd, w_shamt;
    logic [c_XLEN-1:0] w_imm, w_rfA, w_rfB, w_aluIn2, w_aluResult;
    logic [c_XLEN-1:0] w_ldstAddr, w_jumpTarget, w_execNextPc, w_wbData;
    logic [3:0]        w_aluCtl;
    logic              w_isRtype, w_legal, w_isBranch, w_isJump, w_taken;
    logic              w_rfWe, w_retire;
    logic [4:0]        w_wbAddr;

    assign w_op         = r_ir[31:26];
    assign w_rs         = r_ir[25:21];
    assign w_rt         = r_ir[20:16];
    assign w_rd         = r_ir[15:11];
    assign w_shamt      = r_ir[10:6];
    assign w_funct      = r_ir[5:0];
    assign w_imm        = signExt(r_ir[15:0]);
    assign w_isRtype    = (w_op == c_OP_RTYPE);
    assign w_legal      = isLegal(w_op, w_funct);
    assign w_isBranch   = (w_op == c_OP_BEQ) || (w_op == c_OP_BNE);
    assign w_isJump     = (w_op == c_OP_J);
    assign w_taken      = (w_op == c_OP_BEQ) ? (r_a == r_b) :
                          (w_op == c_OP_BNE) ? (r_a != r_b) : 1'b0;
    assign w_jumpTarget = {r_pc[31:28], r_ir[25:0], 2'b00};
    assign w_ldstAddr   = r_a + w_imm;
    assign w_aluCtl     = w_isRtype ? functToAlu(w_funct) : c_ALU_ADD;
    assign w_aluIn2     = w_isRtype ? r_b : w_imm;

    // Illegal-as-NOP keeps the already-incremented PC
    assign w_execNextPc = !w_legal ? r_pc :
                          w_isJump ? w_jumpTarget :
                          w_taken  ? r_aluOut : r_pc;

    // Integer ALU used by R-type and addi in EXEC
    always_comb begin
        w_aluResult = '0;
        case (w_aluCtl)
            c_ALU_ADD: w_aluResult = r_a + w_aluIn2;
            c_ALU_SUB: w_aluResult = r_a - w_aluIn2;
            c_ALU_AND: w_aluResult = r_a & w_aluIn2;
            c_ALU_OR:  w_aluResult = r_a | w_aluIn2;
            c_ALU_SLT: w_aluResult = {31'd0, $signed(r_a) < $signed(w_aluIn2)};
            c_ALU_SLL: w_aluResult = r_b << w_shamt;
            default:   w_aluResult = '0;
        endcase
    end

    // Retire depends on mem_ack for stores, so it is decoded from state
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_EXEC:  w_retire = w_isBranch || w_isJump || !w_legal;
            S_MEM:   w_retire = mem_ack && (w_op == c_OP_SW);
            S_WB:    w_retire = 1'b1;
            default: w_retire = 1'b0;
        endcase
    end

    assign w_rfWe   = (r_state == S_WB);
    assign w_wbAddr = w_isRtype ? w_rd : w_rt;
    assign w_wbData = (w_op == c_OP_LW) ? r_mdr : r_aluOut;

    mc_regfile u_regfile (
        .clk       (clk),
        .i_rdAddrA (w_rs),
        .o_rdDataA (w_rfA),
        .i_rdAddrB (w_rt),
        .o_rdDataB (w_rfB),
        .i_we      (w_rfWe),
        .i_wrAddr  (w_wbAddr),
        .i_wrData  (w_wbData)
    );

    // Control FSM and datapath registers; every completing state launches the next fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_memReq   <= 1'b0;
            r_memWe    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_halted   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (!r_memReq) begin
                        r_memReq  <= 1'b1;
                        r_memWe   <= 1'b0;
                        r_memAddr <= r_pc;
                    end else if (mem_ack) begin
                        r_ir     <= mem_rdata;
                        r_pc     <= r_pc + 32'd4;
                        r_memReq <= 1'b0;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a      <= w_rfA;
                    r_b      <= w_rfB;
                    r_aluOut <= r_pc + (w_imm << 2);
                    if (!w_legal && HALT_ON_ILLEGAL) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_isBranch || w_isJump || !w_legal) begin
                        r_pc      <= w_execNextPc;
                        r_memReq  <= 1'b1;
                        r_memWe   <= 1'b0;
                        r_memAddr <= w_execNextPc;
                        r_state   <= S_FETCH;
                    end else if ((w_op == c_OP_LW) || (w_op == c_OP_SW)) begin
                        r_aluOut   <= w_ldstAddr;
                        r_memReq   <= 1'b1;
                        r_memWe    <= (w_op == c_OP_SW);
                        r_memAddr  <= w_ldstAddr;
                        r_memWdata <= r_b;
                        r_state    <= S_MEM;
                    end else begin
                        r_aluOut <= w_aluResult;
                        r_state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (w_op == c_OP_SW) begin
                            r_memReq  <= 1'b1;
                            r_memWe   <= 1'b0;
                            r_memAddr <= r_pc;
                            r_state   <= S_FETCH;
                        end else begin
                            r_mdr    <= mem_rdata;
                            r_memReq <= 1'b0;
                            r_memWe  <= 1'b0;
                            r_state  <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    r_memReq  <= 1'b1;
                    r_memWe   <= 1'b0;
                    r_memAddr <= r_pc;
                    r_state   <= S_FETCH;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    assign mem_req   = r_memReq;
    assign mem_we    = r_memWe;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign retire    = w_retire;
    assign halted    = r_halted;
    assign dbg_pc    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_mc_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_core
// Description : Directed self-checking bench for mc_core with a unified
//               word memory model and programmable wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ack, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, dbg_pc;

    logic [31:0] mem [0:255];
    int          waitCycles = 0;
    int          waitCnt = 0;
    logic        ackForceLo = 1'b0;
    logic        ackForceHi = 1'b0;
    logic        loadEn = 1'b0;
    logic [7:0]  loadIdx = 8'd0;
    logic [31:0] loadData = 32'd0;

    int checks = 0;
    int errors = 0;
    int retireCnt = 0;

    mc_core #(
        .RESET_PC        (32'h0000_0100),
        .HALT_ON_ILLEGAL (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .retire    (retire),
        .halted    (halted),
        .dbg_pc    (dbg_pc)
    );

    always #5 clk = ~clk;

    assign mem_ack   = ackForceHi | (~ackForceLo & mem_req & (waitCnt >= waitCycles));
    assign mem_rdata = mem[mem_addr[9:2]];

    // Memory model: program loading, store commit, wait-state counting
    always @(posedge clk) begin
        if (loadEn) mem[loadIdx] <= loadData;
        else if (mem_req && mem_ack && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
        if (mem_req && mem_ack) waitCnt <= 0;
        else if (mem_req)       waitCnt <= waitCnt + 1;
        else                    waitCnt <= 0;
    end

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (retire === 1'b1) retireCnt++;
    endtask

    task automatic loadWord(input logic [31:0] byteAddr, input logic [31:0] data);
        loadIdx  = byteAddr[9:2];
        loadData = data;
        loadEn   = 1'b1;
        @(posedge clk);
        #1;
        loadEn = 1'b0;
    endtask

    task automatic beginProgram(input int w);
        reset      = 1'b1;
        ackForceLo = 1'b0;
        ackForceHi = 1'b0;
        waitCycles = w;
        tick();
        tick();
    endtask

    task automatic releaseReset();
        reset     = 1'b0;
        retireCnt = 0;
    endtask

    task automatic runUntilRetire(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (retireCnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        beginProgram(0);
        loadWord(32'h100, encI(6'h04, 5'd0, 5'd0, 16'hFFFF));
        checks++;
        if ({mem_req, mem_we, retire, halted} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: req/we/retire/halted=%b required 0000", {mem_req, mem_we, retire, halted});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h required 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (dbg_pc !== 32'h100) begin
            errors++;
            $display("FAIL reset_pc: dbg_pc=%h required 00000100", dbg_pc);
        end
        releaseReset();
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: mem_req=%b required 0", mem_req);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch: req=%b addr=%h we=%b required 1 00000100 0", mem_req, mem_addr, mem_we);
        end
    endtask

    task automatic test_store_seq();
        beginProgram(0);
        loadWord(32'h100, encI(6'h08, 5'd0, 5'd1, 16'd5));
        loadWord(32'h104, encI(6'h08, 5'd0, 5'd2, 16'd7));
        loadWord(32'h108, encR(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        loadWord(32'h10C, encI(6'h2B, 5'd0, 5'd3, 16'h0040));
        loadWord(32'h110, encI(6'h04, 5'd0, 5'd0, 16'hFFFF));
        loadWord(32'h040, 32'h0);
        releaseReset();
        tick();
        for (int c = 1; c <= 17; c++) begin
            if (c > 1) tick();
            if (c == 15) begin
                checks++;
                if (retireCnt != 3) begin
                    errors++;
                    $display("FAIL seq_retire_15: count=%0d required 3", retireCnt);
                end
            end
            if (c == 16) begin
                checks++;
                if (retireCnt != 4) begin
                    errors++;
                    $display("FAIL seq_retire_16: count=%0d required 4", retireCnt);
                end
            end
        end
        checks++;
        if (mem[16] !== 32'd12) begin
            errors++;
            $display("FAIL seq_store: mem[0x40]=%h required 0000000c", mem[16]);
        end
    endtask

    task automatic test_alu_ops();
        bit ok;
        logic [31:0] exp [0:5];
        beginProgram(0);
        loadWord(32'h100, encI(6'h08, 5'd0, 5'd1, 16'hFFFD));
        loadWord(32'h104, encI(6'h08, 5'd0, 5'd2, 16'd5));
        loadWord(32'h108, encR(5'd1, 5'd2, 5'd3, 5'd0, 6'h2A));
        loadWord(32'h10C, encR(5'd2, 5'd1, 5'd4, 5'd0, 6'h22));
        loadWord(32'h110, encR(5'd1, 5'd2, 5'd5, 5'd0, 6'h24));
        loadWord(32'h114, encR(5'd1, 5'd2, 5'd6, 5'd0, 6'h25));
        loadWord(32'h118, encR(5'd0, 5'd2, 5'd7, 5'd4, 6'h00));
        loadWord(32'h11C, encI(6'h2B, 5'd0, 5'd3, 16'h0048));
        loadWord(32'h120, encI(6'h2B, 5'd0, 5'd4, 16'h004C));
        loadWord(32'h124, encI(6'h2B, 5'd0, 5'd5, 16'h0050));
        loadWord(32'h128, encI(6'h2B, 5'd0, 5'd6, 16'h0054));
        loadWord(32'h12C, encI(6'h2B, 5'd0, 5'd7, 16'h0058));
        loadWord(32'h130, encR(5'd2, 5'd1, 5'd8, 5'd0, 6'h2A));
        loadWord(32'h134, encI(6'h2B, 5'd0, 5'd8, 16'h005C));
        loadWord(32'h138, {6'h02, 26'h60});
        loadWord(32'h13C, encI(6'h2B, 5'd0, 5'd2, 16'h005C));
        loadWord(32'h180, encI(6'h04, 5'd0, 5'd0, 16'hFFFF));
        for (int i = 18; i <= 23; i++) loadWord(32'(i * 4), 32'hAAAA_AAAA);
        exp[0] = 32'd1;  exp[1] = 32'd8;  exp[2] = 32'd5;
        exp[3] = 32'hFFFF_FFFD; exp[4] = 32'h50; exp[5] = 32'd0;
        releaseReset();
        runUntilRetire(15, 200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL alu_timeout: retired=%0d required 15", retireCnt);
        end
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h180) begin
            errors++;
            $display("FAIL jump_target: req=%b addr=%h required 1 00000180", mem_req, mem_addr);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (mem[18 + i] !== exp[i]) begin
                errors++;
                $display("FAIL alu_result_%0d: mem=%h required %h", i, mem[18 + i], exp[i]);
            end
        end
    endtask

    task automatic test_wait_lw();
        int          lwRetire = 0;
        logic        prevReq = 1'b0;
        logic        prevAck = 1'b0;
        logic        prevWe = 1'b0;
        logic [31:0] prevAddr = 32'h0;
        logic [31:0] prevWdata = 32'h0;
        beginProgram(3);
        loadWord(32'h100, encI(6'h23, 5'd0, 5'd4, 16'h0040));
        loadWord(32'h104, encI(6'h2B, 5'd0, 5'd4, 16'h0044));
        loadWord(32'h108, encI(6'h04, 5'd0, 5'd0, 16'hFFFF));
        loadWord(32'h040, 32'd12);
        loadWord(32'h044, 32'd0);
        releaseReset();
        tick();
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) tick();
            if (prevReq && !prevAck) begin
                checks++;
                if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, prevWe, prevAddr, prevWdata}) begin
                    errors++;
                    $display("FAIL wait_stable c%0d: req=%b we=%b addr=%h wd=%h required 1 %b %h %h",
                             c, mem_req, mem_we, mem_addr, mem_wdata, prevWe, prevAddr, prevWdata);
                end
            end
            if (c == 7) begin
                checks++;
                if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40) begin
                    errors++;
                    $display("FAIL lw_access: req=%b we=%b addr=%h required 1 0 00000040", mem_req, mem_we, mem_addr);
                end
            end
            if (retire === 1'b1 && lwRetire == 0) lwRetire = c;
            prevReq = mem_req; prevAck = mem_ack; prevWe = mem_we;
            prevAddr = mem_addr; prevWdata = mem_wdata;
        end
        checks++;
        if (lwRetire != 11) begin
            errors++;
            $display("FAIL lw_latency: retire at cycle %0d required 11", lwRetire);
        end
        checks++;
        if (mem[17] !== 32'd12) begin
            errors++;
            $display("FAIL lw_data: mem[0x44]=%h required 0000000c", mem[17]);
        end
    endtask

    task automatic test_branch();
        logic expRetire;
        beginProgram(0);
        loadWord(32'h100, encI(6'h08, 5'd0, 5'd1, 16'd9));
        loadWord(32'h104, encI(6'h05, 5'd1, 5'd1, 16'd4));
        loadWord(32'h108, encI(6'h04, 5'd1, 5'd1, 16'hFFFF));
        loadWord(32'h118, encI(6'h04, 5'd0, 5'd0, 16'hFFFF));
        releaseReset();
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (c > 1) tick();
            if (c == 8 || c == 11 || c == 14) begin
                checks++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h108 || dbg_pc !== 32'h108) begin
                    errors++;
                    $display("FAIL branch_fetch c%0d: req=%b addr=%h pc=%h required 1 00000108 00000108",
                             c, mem_req, mem_addr, dbg_pc);
                end
            end
            if (c >= 8) begin
                expRetire = (c == 10 || c == 13 || c == 16);
                checks++;
                if (retire !== expRetire) begin
                    errors++;
                    $display("FAIL branch_retire c%0d: retire=%b required %b", c, retire, expRetire);
                end
            end
        end
    endtask

    task automatic test_illegal();
        beginProgram(0);
        loadWord(32'h100, 32'hFC00_0000);
        releaseReset();
        tick();
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) tick();
            if (c == 2) begin
                checks++;
                if (halted !== 1'b0 || retire !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_decode: halted=%b retire=%b required 0 0", halted, retire);
                end
            end
            if (c >= 3) begin
                checks++;
                if (halted !== 1'b1 || mem_req !== 1'b0 || retire !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_halt c%0d: halted=%b req=%b retire=%b required 1 0 0",
                             c, halted, mem_req, retire);
                end
            end
        end
        reset = 1'b1;
        tick();
        checks++;
        if (halted !== 1'b0 || dbg_pc !== 32'h100) begin
            errors++;
            $display("FAIL halt_reset: halted=%b pc=%h required 0 00000100", halted, dbg_pc);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        beginProgram(0);
        loadWord(32'h100, encI(6'h08, 5'd0, 5'd1, 16'd5));
        loadWord(32'h104, encI(6'h2B, 5'd0, 5'd1, 16'h0050));
        loadWord(32'h108, encI(6'h04, 5'd0, 5'd0, 16'hFFFF));
        loadWord(32'h050, 32'hDEAD_BEEF);
        releaseReset();
        tick();
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) tick();
            if (c == 7) ackForceLo = 1'b1;
        end
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h50) begin
            errors++;
            $display("FAIL pending_sw: req=%b we=%b addr=%h required 1 1 00000050", mem_req, mem_we, mem_addr);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (mem_req !== 1'b0 || retire !== 1'b0) begin
            errors++;
            $display("FAIL abort_req: req=%b retire=%b required 0 0", mem_req, retire);
        end
        releaseReset();
        ackForceLo = 1'b0;
        ackForceHi = 1'b1;
        tick();
        ackForceHi = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || retireCnt != 0) begin
            errors++;
            $display("FAIL refetch: req=%b addr=%h we=%b retired=%0d required 1 00000100 0 0",
                     mem_req, mem_addr, mem_we, retireCnt);
        end
        checks++;
        if (mem[20] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL no_write: mem[0x50]=%h required deadbeef", mem[20]);
        end
        runUntilRetire(2, 40, ok);
        tick();
        checks++;
        if (!ok || mem[20] !== 32'd5) begin
            errors++;
            $display("FAIL recover_store: ok=%b mem[0x50]=%h required 1 00000005", ok, mem[20]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_seq();
        test_alu_ops();
        test_wait_lw();
        test_branch();
        test_illegal();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_core.md
# mc_core

Multi-cycle successor to the single-cycle MIPS datapath. It executes the same integer subset over one shared instruction/data memory port with a req/ack handshake, so it tolerates variable-latency memory. It adds illegal-opcode halt, a retire pulse and a parametrised reset vector. It sits between the top-level testbench/SoC and a single unified memory model.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- HALT_ON_ILLEGAL, 1, 1 = enter HALT on an unsupported opcode; 0 = treat it as a NOP (retire, PC+4).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req = 1.
- mem_addr  out  32  byte address, word-aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; sampled in the cycle mem_ack = 1.
- mem_ack  in  1  request complete; ignored while mem_req = 0.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  core is in HALT.
- dbg_pc  out  32  current architectural PC.

## Operation
- Supported instructions:
  - R-type add, sub, and, or, slt, sll (by funct).
  - lw, sw, beq, bne, addi, j.
- Register $0 reads as 0; writes to $0 are discarded.
- Internal registers: PC, IR, A, B, ALUOut, MDR.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - On mem_ack: IR<=mem_rdata, PC<=PC+4, go to DECODE.
- DECODE:
  - A<=rf[rs], B<=rf[rt].
  - ALUOut<=PC+(sext(imm)<<2) (branch target).
  - Illegal opcode: go to HALT (or NOP path per parameter).
- EXEC:
  - R-type/addi: compute result into ALUOut, go to WB.
  - lw/sw: ALUOut<=A+sext(imm), go to MEM.
  - beq/bne: compare A and B; if taken, PC<=ALUOut. Retire, go to FETCH.
  - j: PC<={PC[31:28],IR[25:0],2'b00}. Retire, go to FETCH.
- MEM:
  - mem_req=1, mem_addr=ALUOut.
  - sw: mem_we=1, mem_wdata=B. On ack, retire and go to FETCH.
  - lw: on ack, MDR<=mem_rdata, go to WB.
- WB:
  - Write rf[rd] (R-type), rf[rt] (addi) or rf[rt]<=MDR (lw).
  - Retire, go to FETCH.
- HALT: absorbing; only reset leaves it.
- Arithmetic is 32-bit modulo 2^32; no overflow traps. slt is signed. sll uses shamt=IR[10:6].
- Address bits [1:0] are passed through unchanged; misalignment is not checked.

## Timing
- Reset values:
  - PC=RESET_PC, state=FETCH.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - retire=0, halted=0, dbg_pc=RESET_PC.
  - Register file contents are not reset.
- First mem_req is asserted in the cycle after reset deasserts.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata stay stable until the ack cycle.
  - mem_ack in the same cycle as mem_req is legal (zero wait).
  - mem_req deasserts in the cycle after the ack.
- Cycle counts with zero wait: branch/j = 3, R-type/addi/sw = 4, lw = 5. Each wait cycle adds 1.
- retire is asserted in the final state's cycle (EXEC, MEM or WB). The register write and PC update commit on that edge.
- Reset asserted mid-request:
  - The request aborts at the reset edge.
  - A late ack is ignored because mem_req = 0.
  - No register write or retire occurs.
- Branch with offset -1 targets its own address, so the core spins legally.
- PC wraps 32'hFFFF_FFFC -> 0.
- halted rises on the edge leaving DECODE, with retire=0.

## Structure
- Package mc_pkg holds:
  - Opcode and funct constants.
  - State enum.
  - 4-bit ALU control codes.
  - Width constant 32.
- Sub-module mc_regfile: 32x32, two async read ports, one sync write port, $0 hardwired. The FSM, datapath and ALU stay in mc_core.

## Test plan
- Reset with RESET_PC=32'h100 -> dbg_pc=32'h100; mem_req=1, mem_addr=32'h100 one cycle after reset drops.
- addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sw $3,0x40($0) -> memory word 0x40 = 12. Retire count 4 in 16 cycles with zero-wait memory.
- lw $4,0x40($0) with a memory that waits 3 cycles on every access -> $4=12. The lw takes 11 cycles. mem_addr/mem_we stay stable throughout each wait.
- beq $1,$1,-1 -> the same PC is refetched repeatedly; retire pulses every 3 cycles. bne $1,$1,+4 -> falls through to PC+4.
- Illegal opcode 6'h3F with HALT_ON_ILLEGAL=1 -> halted=1 after 2 cycles. No further mem_req and no retire; reset clears halted.
- Reset asserted during a pending sw with mem_ack held low, then ack pulsed after reset -> no memory write, core refetches RESET_PC.
